// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Initiator side of the word-wide data-memory port. Takes byte/half/word
//   load and store requests from the execute stage, drives the data memory
//   and returns one response per accepted request.
//   Sub-word loads are extracted and sign/zero-extended. Sub-word stores are
//   done as read-modify-write because the memory has no byte enables.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   req_valid/ready   request handshake; transfer when both are high
//   req_write         1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      loads only: 1 = zero-extend, 0 = sign-extend
//   req_addr          byte address from the ALU
//   req_wdata         store data, right-aligned
//   resp_valid        one-cycle completion pulse
//   resp_rdata        load result (0 for stores and rejected requests)
//   resp_misalign     request rejected, memory was not accessed
//   mem_read/write    memory strobes, never both high
//   mem_addr          word address into the data memory
//   mem_wd            memory write data
//   mem_rd            memory read data, valid in the cycle mem_read is high
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_misalign,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wd,
    input  logic [DATA_W-1:0]     mem_rd
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        STORE  = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t state, state_nxt;

    // Request captured at accept
    logic [DM_ADDRESS-1:0] waddr_p0;
    logic [1:0]            off_p0;
    logic [1:0]            size_p0;
    logic                  uns_p0;
    logic [DATA_W-1:0]     wdata_p0;
    logic                  mis_p0;

    // Memory data captured during LOAD / RMW_RD
    logic [DATA_W-1:0]     rdata_p1;
    logic [DATA_W-1:0]     old_p1;

    logic accept;
    logic req_mis;

    // Upper address bits are deliberately dropped: the address space aliases.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[ADDR_W-1:DM_ADDRESS+2];

    // Pick the addressed lane(s) out of a memory word and extend to DATA_W.
    function automatic logic [DATA_W-1:0] load_extend(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        off,
        input logic [1:0]        size,
        input logic              uns
    );
        logic        [7:0]        b;
        logic        [15:0]       h;
        logic signed [7:0]        b_s;
        logic signed [15:0]       h_s;
        logic signed [DATA_W-1:0] ext_s;
        b   = word[{off, 3'b000} +: 8];
        h   = word[{off[1], 4'b0000} +: 16];
        b_s = signed'(b);
        h_s = signed'(h);
        case (size)
            SZ_BYTE: begin
                ext_s = DATA_W'(b_s);
                load_extend = uns ? {{(DATA_W-8){1'b0}}, b} : DATA_W'(ext_s);
            end
            SZ_HALF: begin
                ext_s = DATA_W'(h_s);
                load_extend = uns ? {{(DATA_W-16){1'b0}}, h} : DATA_W'(ext_s);
            end
            default: begin
                ext_s = '0;
                load_extend = word;
            end
        endcase
    endfunction

    // Replace only the addressed lane(s) of the old word with store data.
    function automatic logic [DATA_W-1:0] store_merge(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] wdata,
        input logic [1:0]        off,
        input logic [1:0]        size
    );
        logic [DATA_W-1:0] w;
        w = old;
        case (size)
            SZ_BYTE: w[{off, 3'b000} +: 8]      = wdata[7:0];
            SZ_HALF: w[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: w = wdata;
        endcase
        store_merge = w;
    endfunction

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        req_mis = 1'b0;
        case (req_size)
            SZ_HALF: req_mis = req_addr[0];
            SZ_WORD: req_mis = (req_addr[1:0] != 2'b00);
            SZ_BYTE: req_mis = 1'b0;
            default: req_mis = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_mis)                 state_nxt = RESP;
                    else if (!req_write)         state_nxt = LOAD;
                    else if (req_size == SZ_WORD) state_nxt = STORE;
                    else                         state_nxt = RMW_RD;
                end
            end
            LOAD:    state_nxt = RESP;
            STORE:   state_nxt = RESP;
            RMW_RD:  state_nxt = RMW_WR;
            RMW_WR:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: capture request on accept
    // Stage p1: capture memory read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_p0 <= '0;
            off_p0   <= '0;
            size_p0  <= '0;
            uns_p0   <= 1'b0;
            wdata_p0 <= '0;
            mis_p0   <= 1'b0;
            rdata_p1 <= '0;
            old_p1   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        waddr_p0 <= req_addr[DM_ADDRESS+1:2];
                        off_p0   <= req_addr[1:0];
                        size_p0  <= req_size;
                        uns_p0   <= req_unsigned;
                        wdata_p0 <= req_wdata;
                        mis_p0   <= req_mis;
                        // Stores and rejected requests respond with zero data.
                        rdata_p1 <= '0;
                    end
                end
                LOAD:    rdata_p1 <= load_extend(mem_rd, off_p0, size_p0, uns_p0);
                RMW_RD:  old_p1   <= mem_rd;
                default: ;
            endcase
        end
    end

    // Outputs decoded from state so everything reads zero outside active states.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_addr      = '0;
        mem_wd        = '0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        resp_misalign = 1'b0;
        case (state)
            LOAD, RMW_RD: begin
                mem_read = 1'b1;
                mem_addr = waddr_p0;
            end
            STORE: begin
                mem_write = 1'b1;
                mem_addr  = waddr_p0;
                mem_wd    = wdata_p0;
            end
            RMW_WR: begin
                mem_write = 1'b1;
                mem_addr  = waddr_p0;
                mem_wd    = store_merge(old_p1, wdata_p0, off_p0, size_p0);
            end
            RESP: begin
                resp_valid    = 1'b1;
                resp_rdata    = rdata_p1;
                resp_misalign = mis_p0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int DM_ADDRESS = 9;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;

    logic                  clk;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_misalign;
    logic                  mem_read;
    logic                  mem_write;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wd;
    logic [DATA_W-1:0]     mem_rd;

    logic [DATA_W-1:0] mem [0:(1<<DM_ADDRESS)-1];

    int tests_run;
    int tests_failed;
    int acc_cnt;
    int resp_cnt;
    int wr_cnt;
    int both_cnt;

    load_store_unit #(
        .DM_ADDRESS(DM_ADDRESS),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_misalign(resp_misalign),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-wide memory model: combinational read, write on rising edge.
    assign mem_rd = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wd;
    end

    always @(posedge clk) begin
        if (req_valid && req_ready) acc_cnt++;
        if (resp_valid)             resp_cnt++;
        if (mem_write)              wr_cnt++;
    end
    always @(negedge clk) begin
        if (mem_read && mem_write) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request and follow it until resp_valid (bounded).
    // lat = cycles after the accept edge at which resp_valid was seen (0 = timeout).
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rdata, output logic mis,
                          output int nrd, output int nwr, output logic [31:0] addr_seen);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; rdata = 32'hDEAD_BEEF; mis = 1'bx; nrd = 0; nwr = 0; addr_seen = 32'hFFFF_FFFF;
        for (int c = 1; c <= 8; c++) begin
            if (mem_read)  begin nrd++; addr_seen = 32'(mem_addr); end
            if (mem_write) nwr++;
            if (resp_valid) begin
                lat   = c;
                rdata = resp_rdata;
                mis   = resp_misalign;
                break;
            end
            @(posedge clk); #1;
        end
        // Move past the RESP cycle back to IDLE.
        @(posedge clk); #1;
    endtask

    typedef struct {
        string       tag;
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rdata;
        logic        mis;
        int          nrd;
        int          nwr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int          lat, nrd, nwr, acc0, resp0, wr0;
        logic [31:0] rdata, aseen;
        logic        mis;

        tests_run = 0; tests_failed = 0;
        acc_cnt = 0; resp_cnt = 0; wr_cnt = 0; both_cnt = 0;
        for (int i = 0; i < (1<<DM_ADDRESS); i++) mem[i] = '0;
        mem[4] = 32'h0123_4567;
        mem[5] = 32'h8899_AABB;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",      32'(req_ready),     32'd1);
        check("rst_resp_valid", 32'(resp_valid),    32'd0);
        check("rst_mem_read",   32'(mem_read),      32'd0);
        check("rst_mem_write",  32'(mem_write),     32'd0);
        check("rst_mem_addr",   32'(mem_addr),      32'd0);
        check("rst_mem_wd",     mem_wd,             32'd0);
        check("rst_rdata",      resp_rdata,         32'd0);
        check("rst_misalign",   32'(resp_misalign), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // First load checked in detail: mem_read/mem_addr in N+1, resp in N+2.
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h15; req_wdata = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("t1_n1_mem_read", 32'(mem_read),   32'd1);
        check("t1_n1_mem_addr", 32'(mem_addr),   32'd5);
        check("t1_n1_ready",    32'(req_ready),  32'd0);
        check("t1_n1_resp",     32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_n2_resp",     32'(resp_valid), 32'd1);
        check("t1_n2_rdata",    resp_rdata,      32'hFFFF_FFAA);
        check("t1_n2_mem_read", 32'(mem_read),   32'd0);
        @(posedge clk); #1;
        check("t1_n3_resp",     32'(resp_valid), 32'd0);
        check("t1_n3_rdata",    resp_rdata,      32'd0);
        check("t1_n3_ready",    32'(req_ready),  32'd1);

        //           tag          w     sz     u     addr          wdata         lat rdata          mis  nrd nwr
        vecs.push_back('{"ld_h_u_16", 1'b0, 2'b01, 1'b1, 32'h16,  32'h0,         2, 32'h0000_8899, 1'b0, 1, 0});
        vecs.push_back('{"ld_w_14",   1'b0, 2'b10, 1'b0, 32'h14,  32'h0,         2, 32'h8899_AABB, 1'b0, 1, 0});
        vecs.push_back('{"ld_b_u_14", 1'b0, 2'b00, 1'b1, 32'h14,  32'h0,         2, 32'h0000_00BB, 1'b0, 1, 0});
        vecs.push_back('{"ld_h_s_14", 1'b0, 2'b01, 1'b0, 32'h14,  32'h0,         2, 32'hFFFF_AABB, 1'b0, 1, 0});
        vecs.push_back('{"ld_b_s_17", 1'b0, 2'b00, 1'b0, 32'h17,  32'h0,         2, 32'hFFFF_FF88, 1'b0, 1, 0});
        vecs.push_back('{"st_b_17",   1'b1, 2'b00, 1'b0, 32'h17,  32'h0000_0011, 3, 32'h0,         1'b0, 1, 1});
        vecs.push_back('{"st_h_12",   1'b1, 2'b01, 1'b0, 32'h12,  32'hDEAD_CAFE, 3, 32'h0,         1'b0, 1, 1});
        vecs.push_back('{"st_w_18",   1'b1, 2'b10, 1'b0, 32'h18,  32'h55AA_55AA, 2, 32'h0,         1'b0, 0, 1});
        vecs.push_back('{"mis_st_h",  1'b1, 2'b01, 1'b0, 32'h13,  32'h1234_5678, 1, 32'h0,         1'b1, 0, 0});
        vecs.push_back('{"mis_sz11",  1'b0, 2'b11, 1'b0, 32'h14,  32'h0,         1, 32'h0,         1'b1, 0, 0});
        vecs.push_back('{"mis_ld_w",  1'b0, 2'b10, 1'b0, 32'h16,  32'h0,         1, 32'h0,         1'b1, 0, 0});
        vecs.push_back('{"ld_alias",  1'b0, 2'b10, 1'b0, 32'h814, 32'h0,         2, 32'h1199_AABB, 1'b0, 1, 0});

        foreach (vecs[i]) begin
            do_req(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd,
                   lat, rdata, mis, nrd, nwr, aseen);
            check({vecs[i].tag, "_lat"},   32'(lat),  32'(vecs[i].lat));
            check({vecs[i].tag, "_rdata"}, rdata,     vecs[i].rdata);
            check({vecs[i].tag, "_mis"},   32'(mis),  32'(vecs[i].mis));
            check({vecs[i].tag, "_nrd"},   32'(nrd),  32'(vecs[i].nrd));
            check({vecs[i].tag, "_nwr"},   32'(nwr),  32'(vecs[i].nwr));
            if (vecs[i].tag == "ld_alias") check("ld_alias_addr", aseen, 32'd5);
        end
        check("mem5_after_rmw",  mem[5], 32'h1199_AABB);
        check("mem4_after_rmw",  mem[4], 32'hCAFE_4567);
        check("mem6_after_st_w", mem[6], 32'h55AA_55AA);

        // Back-to-back: req_valid held for two loads.
        acc0 = acc_cnt; resp0 = resp_cnt;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h14; req_wdata = '0;
        @(posedge clk); #1;
        check("b2b_ready_n1", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("b2b_ready_n2", 32'(req_ready), 32'd0);
        check("b2b_resp_n2",  32'(resp_valid), 32'd1);
        @(posedge clk); #1;
        check("b2b_ready_n3", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        check("b2b_ready_n4", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("b2b_resp_n5",  32'(resp_valid), 32'd1);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_accepts", 32'(acc_cnt - acc0),  32'd2);
        check("b2b_resps",   32'(resp_cnt - resp0), 32'd2);

        // Reset during RMW_RD of a byte store: no write, no response.
        wr0 = wr_cnt; resp0 = resp_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h14;
        req_wdata = 32'h0000_0077;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstmid_in_rmw_rd", 32'(mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_mem_read",  32'(mem_read),   32'd0);
        check("rstmid_mem_write", 32'(mem_write),  32'd0);
        check("rstmid_mem_addr",  32'(mem_addr),   32'd0);
        check("rstmid_resp",      32'(resp_valid), 32'd0);
        check("rstmid_ready",     32'(req_ready),  32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rstmid_ready_after", 32'(req_ready),          32'd1);
        check("rstmid_no_write",    32'(wr_cnt - wr0),       32'd0);
        check("rstmid_no_resp",     32'(resp_cnt - resp0),   32'd0);
        check("rstmid_mem5",        mem[5],                  32'h1199_AABB);
        check("never_rd_and_wr",    32'(both_cnt),           32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
